// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Stalls the pipeline via busy_o and emits a one-cycle writeback strobe when the result is ready.
module ex_div #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_we_o
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic               sgn_q;
    logic               rem_sel_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [ADDR_W-1:0]  rd_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  quo_q;
    logic [DATA_W-1:0]  rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               we_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic [DATA_W-1:0]  abs_a;
    logic [DATA_W-1:0]  abs_b;
    logic               div_zero;
    logic               ovf;
    logic [DATA_W-1:0]  special_res;
    logic [DATA_W:0]    shifted;
    logic [DATA_W:0]    diff;
    logic               fit;
    logic [DATA_W-1:0]  rem_nx;
    logic [DATA_W-1:0]  quo_nx;
    logic [DATA_W-1:0]  final_res;

    always_comb begin
        abs_a       = a_q;
        abs_b       = b_q;
        div_zero    = 1'b0;
        ovf         = 1'b0;
        special_res = '0;
        shifted     = '0;
        diff        = '0;
        fit         = 1'b0;
        rem_nx      = '0;
        quo_nx      = '0;
        final_res   = '0;

        if (sgn_q && a_q[DATA_W-1]) abs_a = -a_q;
        if (sgn_q && b_q[DATA_W-1]) abs_b = -b_q;

        div_zero = (b_q == '0);
        ovf      = sgn_q && (a_q == MIN_VAL) && (b_q == '1);
        if (div_zero)
            special_res = rem_sel_q ? a_q : '1;
        else
            special_res = rem_sel_q ? '0 : MIN_VAL;

        // In CALC, b_q holds |divisor| and quo_q shifts the dividend out MSB-first
        // while the quotient bits shift in from the bottom.
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, b_q};
        fit     = ~diff[DATA_W];
        rem_nx  = fit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_nx  = {quo_q[DATA_W-2:0], fit};

        if (rem_sel_q)
            final_res = neg_rem_q ? -rem_nx : rem_nx;
        else
            final_res = neg_quo_q ? -quo_nx : quo_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sgn_q     <= 1'b0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    we_q <= 1'b0;
                    if (start_i && !flush_i) begin
                        sgn_q     <= op_i[2] & ~op_i[0];
                        rem_sel_q <= op_i[1];
                        rd_q      <= reg_waddr_i;
                        a_q       <= dividend_i;
                        b_q       <= divisor_i;
                        busy_q    <= 1'b1;
                        state     <= PREP;
                    end
                end
                PREP: begin
                    if (flush_i) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (div_zero || ovf) begin
                        wdata_q <= special_res;
                        waddr_q <= rd_q;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= DONE;
                    end else begin
                        neg_quo_q <= sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
                        neg_rem_q <= sgn_q & a_q[DATA_W-1];
                        quo_q     <= abs_a;
                        b_q       <= abs_b;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            wdata_q <= final_res;
                            waddr_q <= rd_q;
                            we_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    we_q  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    we_q   <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the DONE cycle must suppress the strobe in that same cycle.
    assign reg_we_o    = we_q & ~flush_i;
    assign busy_o      = busy_q;
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = wdata_q;

endmodule
